// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized rx, mid-bit sampling, LSB-first reassembly,
// level data_av/ack handshake with sticky framing-error and overrun status.
module uart_rx #(
  parameter int RATE_FREQ_BAUD = 434,
  parameter int HALF_BIT       = RATE_FREQ_BAUD / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_av,
  input  logic       ack,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int            CW          = $clog2(RATE_FREQ_BAUD);
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(RATE_FREQ_BAUD - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit_idx, w_bit_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_sync1, r_rx_s;
  logic [7:0]    r_data_out;
  logic          r_data_av, r_framing_error, r_overrun;
  logic          w_stop_ok, w_stop_bad, w_load;

  // Synchronizer resets to the idle-high line level so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      // NOTE: non-blocking so each flop takes the pre-edge value of its source;
      // blocking assignments here would collapse the two stages into one.
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first; any path that skipped
    // an assignment would otherwise infer a latch.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_stop_ok     = 1'b0;
    w_stop_bad    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (r_cnt == C_HALF_LAST) begin
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt   = S_DATA;
            w_bit_idx_nxt = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt              = '0;
          w_shift_nxt[r_bit_idx] = r_rx_s;
          if (r_bit_idx == 3'd7) w_state_nxt   = S_STOP;
          else                   w_bit_idx_nxt = r_bit_idx + 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            w_stop_ok   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A byte lands if the holding register is free or is being read in the same cycle.
  assign w_load = w_stop_ok && (!r_data_av || ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out      <= 8'h00;
      r_data_av       <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      if (w_load) begin
        r_data_out <= r_shift;
        r_data_av  <= 1'b1;
      end else if (ack) begin
        r_data_av <= 1'b0;
      end

      if (w_stop_ok && r_data_av && !ack) r_overrun <= 1'b1;
      else if (ack)                       r_overrun <= 1'b0;

      if (w_stop_bad) r_framing_error <= 1'b1;
      else if (ack)   r_framing_error <= 1'b0;
    end
  end

  assign data_out      = r_data_out;
  assign data_av       = r_data_av;
  assign framing_error = r_framing_error;
  assign overrun       = r_overrun;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model with per-cycle comparison,
// directed scenarios plus randomized frames and ack pulses.
module tb_uart_rx;

  localparam int R   = 16;
  localparam int H   = R / 2;
  localparam int LAT = 3 + H + 9 * R;  // bench edges from rx fall to the stop-sample edge

  logic       clk = 1'b0;
  logic       rst, rx, ack;
  logic [7:0] data_out;
  logic       data_av, framing_error, overrun, busy;

  uart_rx #(.RATE_FREQ_BAUD(R)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .data_out      (data_out),
    .data_av       (data_av),
    .ack           (ack),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef enum {EV_BUSY_ON, EV_BUSY_OFF, EV_GOOD, EV_BAD} ev_kind_t;
  typedef struct {
    int         at;
    ev_kind_t   kind;
    logic [7:0] b;
  } ev_t;

  ev_t        evq[$];
  ev_t        ev;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] m_data;
  logic       m_av, m_fe, m_ov, m_busy;
  logic       ev_good, ev_bad;
  logic [7:0] ev_byte;
  int         av_rise_cyc = -1;
  logic       busy_at_rise = 1'b1;
  logic       prev_av = 1'b0;
  int         last_base;
  logic       rand_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Reference model: frame outcomes are scheduled at known edges; handshake rules applied per edge.
  initial begin
    m_data = 8'h00; m_av = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_busy = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        evq.delete();
        m_data = 8'h00; m_av = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_busy = 1'b0;
      end else begin
        ev_good = 1'b0;
        ev_bad  = 1'b0;
        ev_byte = 8'h00;
        while (evq.size() > 0 && evq[0].at == cyc) begin
          ev = evq.pop_front();
          case (ev.kind)
            EV_BUSY_ON:  m_busy = 1'b1;
            EV_BUSY_OFF: m_busy = 1'b0;
            EV_GOOD:     begin ev_good = 1'b1; ev_byte = ev.b; end
            EV_BAD:      ev_bad = 1'b1;
            default:     ;
          endcase
        end
        if (ev_good && (!m_av || ack)) begin
          m_data = ev_byte;
          m_av   = 1'b1;
          m_ov   = 1'b0;
        end else if (ev_good) begin
          m_ov = 1'b1;
        end else if (ack) begin
          m_av = 1'b0;
          m_ov = 1'b0;
        end
        if (ev_bad)   m_fe = 1'b1;
        else if (ack) m_fe = 1'b0;
      end
      check("cycle", 32'({data_out, data_av, framing_error, overrun, busy}),
            32'({m_data, m_av, m_fe, m_ov, m_busy}));
      if (data_av && !prev_av) begin
        av_rise_cyc  = cyc;
        busy_at_rise = busy;
      end
      prev_av = data_av;
    end
  end

  // Drives one 8N1 frame starting at a negedge; optional reset or ack at frame-relative cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int rst_at,
                            input int ack_at);
    int         base;
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    base = cyc;
    last_base = base;
    evq.push_back('{base + 3, EV_BUSY_ON, 8'h00});
    evq.push_back('{base + LAT, stop_ok ? EV_GOOD : EV_BAD, b});
    evq.push_back('{base + (stop_ok ? LAT : LAT + 8), EV_BUSY_OFF, 8'h00});
    for (int i = 0; i < 10 * R; i++) begin
      rx = bits[i / R];
      if (ack_at >= 0) ack = (i == ack_at);
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check("async_reset", 32'({data_out, data_av, framing_error, overrun, busy}), 32'h0);
      end else begin
        rst = 1'b0;
      end
      @(negedge clk);
    end
    rx = 1'b1;
    if (ack_at >= 0) ack = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1; rx = 1'b1; ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({data_out, data_av, framing_error, overrun, busy}), 32'h0);
    rst = 1'b0;
    idle(10);

    // 1: single byte, latency and busy ordering
    send_frame(8'hA5, 1'b1, -1, -1);
    base = last_base;
    idle(20);
    check("t1_data", 32'(data_out), 32'hA5);
    check("t1_flags", 32'({data_av, framing_error, overrun}), 32'b100);
    check("t1_latency", 32'(av_rise_cyc - base), 32'd155);
    check("t1_busy_at_rise", 32'(busy_at_rise), 32'd0);
    pulse_ack();
    check("t1_ack_clears", 32'(data_av), 32'd0);

    // 2: overrun
    send_frame(8'h3C, 1'b1, -1, -1);
    idle(20);
    send_frame(8'h81, 1'b1, -1, -1);
    idle(20);
    check("t2_data_kept", 32'(data_out), 32'h3C);
    check("t2_overrun", 32'({data_av, overrun}), 32'b11);
    pulse_ack();
    check("t2_ack_clears", 32'({data_av, overrun}), 32'b00);

    // 3: framing error, WAIT_IDLE, recovery
    send_frame(8'h55, 1'b0, -1, -1);
    check("t3_wait_idle_busy", 32'(busy), 32'd1);
    idle(20);
    check("t3_framing", 32'({data_av, framing_error, busy}), 32'b010);
    send_frame(8'h0F, 1'b1, -1, -1);
    idle(20);
    check("t3_recover_data", 32'(data_out), 32'h0F);
    check("t3_recover_flags", 32'({data_av, framing_error}), 32'b11);
    pulse_ack();
    check("t3_ack_clears", 32'({data_av, framing_error}), 32'b00);

    // 4: short glitch is a false start
    base = cyc;
    evq.push_back('{base + 3, EV_BUSY_ON, 8'h00});
    evq.push_back('{base + 3 + H, EV_BUSY_OFF, 8'h00});
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_start_busy", 32'(busy), 32'd1);
    idle(20);
    check("t4_no_effect", 32'({data_av, framing_error, overrun, busy}), 32'h0);

    // 5: reset in the middle of bit 4
    send_frame(8'hFF, 1'b1, 5 * R + R / 2, -1);
    idle(20);
    check("t5_no_partial", 32'({data_out, data_av, framing_error, overrun, busy}), 32'h0);
    send_frame(8'h00, 1'b1, -1, -1);
    idle(20);
    check("t5_next_frame", 32'({data_out, data_av}), 32'({8'h00, 1'b1}));
    pulse_ack();

    // 6: back-to-back with ack on the second stop sample
    send_frame(8'h01, 1'b1, -1, -1);
    send_frame(8'h02, 1'b1, -1, LAT - 1);
    idle(20);
    check("t6_data", 32'(data_out), 32'h02);
    check("t6_flags", 32'({data_av, overrun}), 32'b10);
    pulse_ack();

    // Random frames with concurrent random ack pulses
    rand_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 24; f++) begin
          send_frame(8'($urandom), ($urandom_range(0, 99) < 85), -1, -1);
          idle($urandom_range(16, 60));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          int k;
          k = $urandom_range(10, 250);
          while (!rand_done && k > 0) begin
            @(negedge clk);
            k--;
          end
          if (!rand_done) pulse_ack();
        end
      end
    join

    pulse_ack();
    idle(5);
    check("final_clear", 32'({data_av, framing_error, overrun, busy}), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial 8N1 UART receiver; counterpart of the UART_TX peripheral in the MIPS microcontroller.
- Samples the asynchronous rx pin, reassembles bytes LSB-first, and presents each byte to the CPU bus logic through a level data_av / ack handshake.
- Exposes framing-error and overrun status for a memory-mapped status register and an IRQ line to the InterruptController.
- Clocked on the same (inverted) system clock as the other peripherals.

Parameters:
- RATE_FREQ_BAUD, 434, clock cycles per bit (50 MHz / 115200); must be >= 4.
- HALF_BIT, RATE_FREQ_BAUD/2, cycles from the detected start edge to mid-start-bit sample (integer division).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  8  last received byte.
- data_av  output  1  byte available; level, held until ack.
- ack  input  1  one-cycle pulse from the CPU read of the RX data register; consumes the byte.
- framing_error  output  1  sticky: stop bit sampled low.
- overrun  output  1  sticky: byte completed while data_av=1.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, shift register=0, data_out=8'h00, data_av=0, framing_error=0, overrun=0, busy=0. Synchronizer flops reset to 1.
- rx passes through a 2-flop synchronizer, producing rx_s. All FSM decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - rx_s==0 -> START, counter=0.
- START:
  - Count HALF_BIT-1 cycles, then sample rx_s.
  - rx_s==1 -> false start, return to IDLE; no flags change.
  - rx_s==0 -> DATA, counter=0, bit index=0.
- DATA:
  - Every RATE_FREQ_BAUD cycles (counter reaches RATE_FREQ_BAUD-1), shift rx_s into bit [index], LSB first.
  - After bit 7 -> STOP, counter=0.
- STOP:
  - After RATE_FREQ_BAUD cycles, sample rx_s.
  - rx_s==1 (valid byte), outcome depends on the handshake:
    - data_av==0, or ack in the same cycle: data_out<=shift register, data_av<=1 on the next rising edge. Go to IDLE.
    - data_av==1 and no ack: byte discarded, data_out unchanged, overrun<=1. Go to IDLE.
  - rx_s==0: framing_error<=1, byte discarded, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_s==1, then go to IDLE. Prevents a held-low line (break) from retriggering START.
- ack:
  - Clears data_av, overrun and framing_error on the next edge.
  - If ack and a valid stop sample coincide, the new byte loads, data_av stays 1, overrun stays 0.
  - ack while data_av==0 only clears the error flags.
- Latency: from the falling edge of the start bit at the rx pin to data_av=1 is 2 + HALF_BIT + 9*RATE_FREQ_BAUD + 1 cycles (±1 for edge alignment).
- busy=1 in START, DATA, STOP and WAIT_IDLE.
- Reset mid-frame returns immediately to IDLE with all outputs at reset values. A partial frame is never reported.
- Counter width is $clog2(RATE_FREQ_BAUD); the counter never wraps past RATE_FREQ_BAUD-1.
- Integration (top level):
  - Read of 0xFFFF_FF18 returns {24'b0, data_out} and generates the ack pulse.
  - UART_STATUS bits [1],[2],[3] = data_av, framing_error, overrun.
  - data_av drives a free irq line.

Test Plan:
1. RATE_FREQ_BAUD=16, send 8'hA5 (8N1, 16 clk/bit) -> data_av rises; data_out=8'hA5; framing_error=0; overrun=0; busy falls before data_av rises.
2. Send 8'h3C, hold ack low, then send 8'h81 -> after the second stop bit data_out=8'h3C, overrun=1. Pulse ack -> data_av=0, overrun=0.
3. Send 8'h55 with the stop bit driven low for 16 clk, then rx high -> framing_error=1, data_av=0. FSM passes through WAIT_IDLE, returns to IDLE, and a subsequent 8'h0F receives correctly.
4. 4-cycle low glitch on rx (shorter than HALF_BIT=8) -> FSM returns to IDLE from START; data_av, framing_error and overrun stay 0.
5. Assert rst for 1 cycle in the middle of bit 4 of 8'hFF -> all outputs at reset values immediately. The next frame 8'h00 is received as 8'h00.
6. Back-to-back frames 8'h01, 8'h02, with ack pulsed in the same cycle as the second stop-bit sample -> data_out=8'h02, data_av=1, overrun=0.
